// File: rtl/serial_comparator_ctrl.sv
// Bit-serial magnitude comparator, MSB first, with a one-cycle done pulse.
// Optional macro EARLY_EXIT_EN ends the scan on the first mismatching bit.
module serial_comparator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             GT,
    output logic             EQ,
    output logic             LT
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [IDX_W-1:0]   bit_idx;
    logic               mismatch;
    logic               dir_gt;
    logic               bit_gt;
    logic               bit_lt;
    logic               res_gt;
    logic               res_lt;
    logic               scan_last;

    // Once a mismatch is recorded, later bits cannot change the direction.
    always_comb begin
        bit_gt = a_reg[bit_idx] & ~b_reg[bit_idx];
        bit_lt = ~a_reg[bit_idx] & b_reg[bit_idx];
        res_gt = mismatch ? dir_gt  : bit_gt;
        res_lt = mismatch ? ~dir_gt : bit_lt;
`ifdef EARLY_EXIT_EN
        scan_last = (bit_idx == '0) || bit_gt || bit_lt;
`else
        scan_last = (bit_idx == '0);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (scan_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SCAN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            bit_idx  <= '0;
            mismatch <= 1'b0;
            dir_gt   <= 1'b0;
            GT       <= 1'b0;
            EQ       <= 1'b0;
            LT       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        bit_idx  <= IDX_W'(WIDTH - 1);
                        mismatch <= 1'b0;
                        dir_gt   <= 1'b0;
                        GT       <= 1'b0;
                        EQ       <= 1'b0;
                        LT       <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!mismatch && (bit_gt || bit_lt)) begin
                        mismatch <= 1'b1;
                        dir_gt   <= bit_gt;
                    end
                    if (scan_last) begin
                        GT <= res_gt;
                        LT <= res_lt;
                        EQ <= ~(res_gt | res_lt);
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_comparator_ctrl.md
SERIAL_COMPARATOR_CTRL -- requirements
Module: serial_comparator_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request to begin a comparison; sampled on rising clk.
REQ-005 A  input  WIDTH  operand A (unsigned), sampled only on an accepted start.
REQ-006 B  input  WIDTH  operand B (unsigned), sampled only on an accepted start.
REQ-007 busy  output  1  high while a comparison is in progress (state SCAN).
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 GT  output  1  registered result: A > B.
REQ-010 EQ  output  1  registered result: A == B.
REQ-011 LT  output  1  registered result: A < B.

Function
REQ-012 The block SHALL implement states IDLE, SCAN and DONE.
REQ-013 IDLE: start=1 on a rising edge SHALL capture A and B into internal registers, set the bit index to WIDTH-1, clear GT/EQ/LT to 000, clear the mismatch flag, and enter SCAN.
REQ-014 start SHALL be accepted only in IDLE; start in SCAN or DONE SHALL be ignored and SHALL NOT alter captured operands.
REQ-015 SCAN: each rising edge SHALL evaluate exactly one bit pair, MSB first, using 1-bit compare semantics (a>b, a==b, a<b).
REQ-016 The first mismatching bit SHALL set the mismatch flag and record direction (a=1,b=0 -> greater; a=0,b=1 -> less); later bits SHALL NOT change the recorded direction.
REQ-017 SCAN SHALL exit to DONE after evaluating bit 0, or earlier per REQ-025.
REQ-018 On the edge entering DONE, GT/EQ/LT SHALL be loaded: greater -> 100, less -> 001, no mismatch -> 010; exactly one SHALL be high.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 GT/EQ/LT SHALL hold their value from DONE until the next accepted start.
REQ-021 busy SHALL be 1 exactly in SCAN; done SHALL be 1 exactly in DONE; busy and done SHALL never both be 1.
REQ-022 Latency (no early exit): done high after the WIDTH-th rising edge following the start-accept edge.
REQ-023 Back-to-back: start held high continuously SHALL begin a new comparison on the edge leaving DONE->IDLE +1 (i.e. first IDLE cycle); no start is queued.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, busy=0, done=0, GT=0, EQ=0, LT=0, bit index and mismatch flag to 0, regardless of clk; a comparison in progress SHALL be abandoned with no done pulse; operation resumes with the first start after rst deasserts.

Configuration
REQ-025 Macro EARLY_EXIT_EN: when defined, SCAN SHALL enter DONE on the edge that evaluates the first mismatching bit (bit i mismatch -> done after WIDTH-i edges); when undefined, SCAN SHALL always evaluate all WIDTH bits. GT/EQ/LT results SHALL be identical in both builds.

Verification (WIDTH=8)
REQ-026 A=8'hA5, B=8'hA5, start 1 cycle -> busy for 8 cycles, done pulse after 8th edge, GT/EQ/LT=010, held in IDLE.
REQ-027 A=8'h80, B=8'h7F -> GT/EQ/LT=100; done after 1 edge with EARLY_EXIT_EN, after 8 edges without.
REQ-028 A=8'h04, B=8'h05 -> GT/EQ/LT=001; done after 8 edges in both builds (mismatch at bit 0).
REQ-029 Start A=8'h10,B=8'h20; during SCAN pulse start with A=8'hFF,B=8'h00 -> ignored, result 001, exactly one done pulse.
REQ-030 Start A=8'h00,B=8'h00, assert rst asynchronously mid-SCAN (between edges) -> busy, done, GT/EQ/LT all 0 immediately, no done pulse; next start A=8'h01,B=8'h00 -> 100.
REQ-031 start held high for 30 cycles with A=8'h33,B=8'h33 -> repeated comparisons, each done pulse followed by one IDLE cycle, EQ=1 after each.
